// File: rtl/alu_operand_issue_if.sv
// Decode-side and ALU-side signal bundle for the operand issue stage.
// slave is the stage's own view; master is the view of whoever drives it.
interface alu_operand_issue_if #(
    parameter int XLEN   = 32,
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
);
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [OP_W-1:0]   alu_op_i;
    logic              src_a_sel_i;
    logic              src_b_sel_i;
    logic [REG_AW-1:0] rs1_addr_i;
    logic [REG_AW-1:0] rs2_addr_i;
    logic [XLEN-1:0]   rs1_data_i;
    logic [XLEN-1:0]   rs2_data_i;
    logic [XLEN-1:0]   pc_i;
    logic [XLEN-1:0]   imm_i;
    logic [REG_AW-1:0] rd_addr_i;
    logic              rd_we_i;
    logic              fwd_we_i;
    logic [REG_AW-1:0] fwd_rd_i;
    logic [XLEN-1:0]   fwd_data_i;
    logic              alu_valid_o;
    logic              alu_ready_i;
    logic [OP_W-1:0]   ALUop_o;
    logic [XLEN-1:0]   operand_A;
    logic [XLEN-1:0]   operand_B;
    logic [REG_AW-1:0] rd_addr_o;
    logic              rd_we_o;

    modport slave (
        input  flush_i, valid_i, alu_op_i, src_a_sel_i, src_b_sel_i,
               rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               rd_addr_i, rd_we_i, fwd_we_i, fwd_rd_i, fwd_data_i, alu_ready_i,
        output ready_o, alu_valid_o, ALUop_o, operand_A, operand_B,
               rd_addr_o, rd_we_o
    );

    modport master (
        output flush_i, valid_i, alu_op_i, src_a_sel_i, src_b_sel_i,
               rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               rd_addr_i, rd_we_i, fwd_we_i, fwd_rd_i, fwd_data_i, alu_ready_i,
        input  ready_o, alu_valid_o, ALUop_o, operand_A, operand_B,
               rd_addr_o, rd_we_o
    );
endinterface

// File: rtl/alu_operand_issue.sv
// Execute-entry stage: operand select with writeback forwarding, a main plus
// skid entry toward the ALU, and writeback snooping on held operands.
module alu_operand_issue #(
    parameter int XLEN   = 32,
    parameter int OP_W   = 6,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_operand_issue_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              a_reg;
        logic              b_reg;
        logic [REG_AW-1:0] rd;
        logic              we;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d;
    entry_t new_e, main_s, skid_s;
    logic   accept, drain;

    logic [REG_AW-1:0] src_addr [2];
    logic [XLEN-1:0]   src_data [2];
    logic [XLEN-1:0]   src_val  [2];

    assign src_addr[0] = bus.rs1_addr_i;
    assign src_addr[1] = bus.rs2_addr_i;
    assign src_data[0] = bus.rs1_data_i;
    assign src_data[1] = bus.rs2_data_i;

    // x0 reads as zero even if the writeback bus claims to target it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_val[gi] = (src_addr[gi] == '0) ? '0 :
                                 (bus.fwd_we_i && bus.fwd_rd_i == src_addr[gi]) ? bus.fwd_data_i :
                                 src_data[gi];
        end
    endgenerate

    function automatic entry_t snoop(input entry_t e, input logic we,
                                     input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (we && rd != '0) begin
            if (e.a_reg && e.rs1 == rd) r.a = d;
            if (e.b_reg && e.rs2 == rd) r.b = d;
        end
        return r;
    endfunction

    always_comb begin
        new_e       = '0;
        new_e.valid = 1'b1;
        new_e.op    = bus.alu_op_i;
        new_e.a     = bus.src_a_sel_i ? bus.pc_i : src_val[0];
        new_e.b     = bus.src_b_sel_i ? bus.imm_i : src_val[1];
        new_e.rs1   = bus.rs1_addr_i;
        new_e.rs2   = bus.rs2_addr_i;
        new_e.a_reg = !bus.src_a_sel_i;
        new_e.b_reg = !bus.src_b_sel_i;
        new_e.rd    = bus.rd_addr_i;
        new_e.we    = bus.rd_we_i;
    end

    assign bus.ready_o = !skid_q.valid && !rst_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign drain       = main_q.valid && bus.alu_ready_i;
    assign main_s      = snoop(main_q, bus.fwd_we_i, bus.fwd_rd_i, bus.fwd_data_i);
    assign skid_s      = snoop(skid_q, bus.fwd_we_i, bus.fwd_rd_i, bus.fwd_data_i);

    // A draining entry is left untouched so the idle payload keeps its last value.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (bus.flush_i) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else begin
            case ({skid_q.valid, main_q.valid})
                2'b00: begin
                    if (accept) main_d = new_e;
                end
                2'b01: begin
                    if (accept && drain) begin
                        main_d = new_e;
                    end else if (accept) begin
                        main_d = main_s;
                        skid_d = new_e;
                    end else if (drain) begin
                        main_d.valid = 1'b0;
                    end else begin
                        main_d = main_s;
                    end
                end
                2'b11: begin
                    if (drain) begin
                        main_d       = skid_s;
                        skid_d.valid = 1'b0;
                    end else begin
                        main_d = main_s;
                        skid_d = skid_s;
                    end
                end
                default: begin
                    main_d = main_q;
                    skid_d = skid_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign bus.alu_valid_o = main_q.valid;
    assign bus.ALUop_o     = main_q.op;
    assign bus.operand_A   = main_q.a;
    assign bus.operand_B   = main_q.b;
    assign bus.rd_addr_o   = main_q.rd;
    assign bus.rd_we_o     = main_q.we;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: expected entries are queued at accept,
// updated by writeback snoops while held, and compared when the ALU drains them.
module tb_alu_operand_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_operand_issue_if #(.XLEN(32), .OP_W(6), .REG_AW(5)) bus ();
    alu_operand_issue #(.XLEN(32), .OP_W(6), .REG_AW(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          a_reg;
        bit          b_reg;
        logic [4:0]  rd;
        bit          we;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 5'd0) return 32'd0;
        if (bus.fwd_we_i && bus.fwd_rd_i == addr) return bus.fwd_data_i;
        return data;
    endfunction

    task automatic drive(input logic [5:0] op, input bit as, input bit bs,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pcv, input logic [31:0] immv,
                         input logic [4:0] rd, input bit we);
        bus.valid_i     = 1'b1;
        bus.alu_op_i    = op;
        bus.src_a_sel_i = as;
        bus.src_b_sel_i = bs;
        bus.rs1_addr_i  = r1;
        bus.rs2_addr_i  = r2;
        bus.rs1_data_i  = d1;
        bus.rs2_data_i  = d2;
        bus.pc_i        = pcv;
        bus.imm_i       = immv;
        bus.rd_addr_i   = rd;
        bus.rd_we_i     = we;
    endtask

    task automatic fwd(input bit we, input logic [4:0] rd, input logic [31:0] d);
        bus.fwd_we_i   = we;
        bus.fwd_rd_i   = rd;
        bus.fwd_data_i = d;
    endtask

    // One clock: score the edge's drain/snoop/accept, then check occupancy flags.
    task automatic step();
        exp_t e;
        bit   acc, drn;
        #1;
        acc = bus.valid_i && bus.ready_o && !rst;
        drn = bus.alu_valid_o && bus.alu_ready_i && !rst;
        if (drn) begin
            if (q.size() == 0) begin
                check("spurious_drain", {63'd0, bus.alu_valid_o}, 64'd0);
            end else begin
                e = q.pop_front();
                check("drain_op", {58'd0, bus.ALUop_o}, {58'd0, e.op});
                check("drain_a", {32'd0, bus.operand_A}, {32'd0, e.a});
                check("drain_b", {32'd0, bus.operand_B}, {32'd0, e.b});
                check("drain_rd", {59'd0, bus.rd_addr_o}, {59'd0, e.rd});
                check("drain_we", {63'd0, bus.rd_we_o}, {63'd0, e.we});
                $display("drain op=%0h A=%0h B=%0h rd=%0d we=%0d", bus.ALUop_o,
                         bus.operand_A, bus.operand_B, bus.rd_addr_o, bus.rd_we_o);
            end
        end
        if (rst || bus.flush_i) begin
            q.delete();
        end else begin
            if (bus.fwd_we_i && bus.fwd_rd_i != 5'd0) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    if (e.a_reg && e.rs1 == bus.fwd_rd_i) e.a = bus.fwd_data_i;
                    if (e.b_reg && e.rs2 == bus.fwd_rd_i) e.b = bus.fwd_data_i;
                    q[i] = e;
                end
            end
            if (acc) begin
                e.op    = bus.alu_op_i;
                e.a     = bus.src_a_sel_i ? bus.pc_i : reg_val(bus.rs1_addr_i, bus.rs1_data_i);
                e.b     = bus.src_b_sel_i ? bus.imm_i : reg_val(bus.rs2_addr_i, bus.rs2_data_i);
                e.rs1   = bus.rs1_addr_i;
                e.rs2   = bus.rs2_addr_i;
                e.a_reg = !bus.src_a_sel_i;
                e.b_reg = !bus.src_b_sel_i;
                e.rd    = bus.rd_addr_i;
                e.we    = bus.rd_we_i;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("alu_valid", {63'd0, bus.alu_valid_o}, {63'd0, q.size() != 0});
        check("ready", {63'd0, bus.ready_o}, {63'd0, (q.size() < 2) && !rst});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_op"}, {58'd0, bus.ALUop_o}, 64'd0);
        check({tag, "_a"}, {32'd0, bus.operand_A}, 64'd0);
        check({tag, "_b"}, {32'd0, bus.operand_B}, 64'd0);
        check({tag, "_rd"}, {59'd0, bus.rd_addr_o}, 64'd0);
        check({tag, "_we"}, {63'd0, bus.rd_we_o}, 64'd0);
    endtask

    initial begin
        bus.flush_i = 0; bus.valid_i = 0; bus.alu_ready_i = 0;
        drive(6'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0);
        bus.valid_i = 0;
        fwd(0, 5'd0, 0);

        // Reset
        step(); step();
        check_zero("rst");
        rst = 0;
        step();

        // Plain issue, capture forwarding, x0, PC/imm
        bus.alu_ready_i = 1;
        drive(6'b000_001, 0, 0, 5'd1, 5'd2, 200, 14, 0, 0, 5'd3, 1);
        step();
        check("issue_a", {32'd0, bus.operand_A}, 64'd200);
        check("issue_b", {32'd0, bus.operand_B}, 64'd14);
        fwd(1, 5'd1, 300);
        step();
        check("fwd_a", {32'd0, bus.operand_A}, 64'd300);
        fwd(0, 5'd0, 0);
        drive(6'b000_001, 0, 0, 5'd0, 5'd2, 55, 14, 0, 0, 5'd3, 1);
        step();
        check("x0_a", {32'd0, bus.operand_A}, 64'd0);
        drive(6'b000_100, 1, 1, 5'd1, 5'd2, 7, 8, 32'h100, 32'hFFFF_FFF0, 5'd4, 0);
        step();
        check("pc_a", {32'd0, bus.operand_A}, 64'h100);
        check("imm_b", {32'd0, bus.operand_B}, 64'hFFFF_FFF0);
        bus.valid_i = 0;
        step();

        // Stall fills to TWO, then FIFO drain
        bus.alu_ready_i = 0;
        drive(6'b000_010, 0, 1, 5'd6, 5'd0, 21, 0, 0, 32'd5, 5'd6, 1);
        step();
        drive(6'b000_011, 0, 1, 5'd7, 5'd0, 22, 0, 0, 32'd6, 5'd7, 1);
        step();
        bus.valid_i = 0;
        step();
        bus.alu_ready_i = 1;
        step(); step(); step();

        // Snoop while stalled, main and skid, PC operand immune
        bus.alu_ready_i = 0;
        drive(6'b000_101, 1, 0, 5'd5, 5'd5, 1, 14, 32'h40, 0, 5'd8, 1);
        step();
        drive(6'b000_110, 0, 1, 5'd7, 5'd0, 3, 0, 0, 32'd9, 5'd9, 1);
        fwd(1, 5'd5, 99);
        step();
        check("snoop_b", {32'd0, bus.operand_B}, 64'd99);
        check("pc_nosnoop", {32'd0, bus.operand_A}, 64'h40);
        bus.valid_i = 0;
        fwd(1, 5'd7, 11);
        step();
        fwd(0, 5'd0, 0);
        bus.alu_ready_i = 1;
        step(); step();

        // Flush at TWO together with a new instruction
        bus.alu_ready_i = 0;
        drive(6'b001_000, 0, 0, 5'd1, 5'd2, 1, 2, 0, 0, 5'd1, 1);
        step();
        drive(6'b001_001, 0, 0, 5'd1, 5'd2, 3, 4, 0, 0, 5'd2, 1);
        step();
        drive(6'b001_010, 0, 0, 5'd1, 5'd2, 5, 6, 0, 0, 5'd3, 1);
        bus.flush_i = 1;
        step();
        bus.flush_i = 0;
        bus.valid_i = 0;
        bus.alu_ready_i = 1;
        step(); step();

        // Reset mid-stall
        bus.alu_ready_i = 0;
        drive(6'b001_011, 0, 0, 5'd3, 5'd4, 9, 10, 0, 0, 5'd5, 1);
        step();
        bus.valid_i = 0;
        rst = 1;
        step();
        check_zero("rst_mid");
        rst = 0;
        bus.alu_ready_i = 1;
        step(); step();

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            drive(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            bus.valid_i     = 1'($urandom_range(0, 1));
            bus.alu_ready_i = 1'($urandom_range(0, 2) != 0);
            fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            step();
        end
        bus.valid_i = 0;
        bus.alu_ready_i = 1;
        fwd(0, 5'd0, 0);
        step(); step(); step();
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
